// File: rtl/bshift8_pkg.sv
// rtl/bshift8_pkg.sv - shared encodings and pipeline-slot type for the 8-bit barrel shifter
package bshift8_pkg;

    typedef enum logic [1:0] {
        MODE_LOG  = 2'b00,
        MODE_ARI  = 2'b01,
        MODE_ROT  = 2'b10,
        MODE_PASS = 2'b11
    } mode_t;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    typedef struct packed {
        logic [7:0] data;
        logic       dir;
        mode_t      mode;
        logic [2:0] shamt;
        logic       valid;
    } slot_t;

    localparam slot_t SLOT_IDLE = '{
        data:  8'h00,
        dir:   DIR_L,
        mode:  MODE_PASS,
        shamt: 3'd0,
        valid: 1'b0
    };

endpackage

// File: rtl/bshift8_stage_if.sv
// rtl/bshift8_stage_if.sv - operand/result handshake bundle for bshift8_stage
interface bshift8_stage_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic [2:0] shamt;
    logic       dir;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;

    modport master (
        output in_valid, din, shamt, dir, mode, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, din, shamt, dir, mode, out_ready,
        output in_ready, out_valid, dout
    );

endinterface

// File: rtl/bshift8_level.sv
// rtl/bshift8_level.sv - one combinational barrel-shifter level of fixed distance DIST
module bshift8_level
    import bshift8_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic [7:0] data_i,
    input  logic       dir_i,
    input  mode_t      mode_i,
    input  logic       en_i,
    output logic [7:0] data_o
);

    mode_t sel;
    assign sel = en_i ? mode_i : MODE_PASS;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        // Source positions wrap modulo 8; the *_IN flags say whether the source lies inside the byte.
        localparam int  LI   = (i - DIST + 8) % 8;
        localparam int  RI   = (i + DIST) % 8;
        localparam bit  L_IN = (i >= DIST);
        localparam bit  R_IN = ((i + DIST) < 8);

        logic shf_b;
        logic ari_b;
        logic rot_b;
        logic bit_o;

        always_comb begin
            if (dir_i == DIR_L) begin
                shf_b = L_IN ? data_i[LI] : 1'b0;
                ari_b = shf_b;
                rot_b = data_i[LI];
            end else begin
                shf_b = R_IN ? data_i[RI] : 1'b0;
                ari_b = R_IN ? data_i[RI] : data_i[7];
                rot_b = data_i[RI];
            end
        end

        always_comb begin
            case (sel)
                MODE_LOG: bit_o = shf_b;
                MODE_ARI: bit_o = ari_b;
                MODE_ROT: bit_o = rot_b;
                default:  bit_o = data_i[i];
            endcase
        end

        assign data_o[i] = bit_o;
    end

endmodule

// File: rtl/bshift8_stage.sv
// rtl/bshift8_stage.sv - handshaked 8-bit barrel shifter; BSHIFT8_STAGE_PIPE_EN selects 3-register pipeline
module bshift8_stage
    import bshift8_pkg::*;
#(
    parameter logic [7:0] RESET_DOUT = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    bshift8_stage_if.slave bus
);

    logic [7:0] l1_in, l1_out, l2_in, l2_out, l4_in, l4_out;
    logic       l1_dir, l2_dir, l4_dir;
    mode_t      l1_mode, l2_mode, l4_mode;
    logic       l1_en, l2_en, l4_en;

    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_rdy;

    assign l1_in   = bus.din;
    assign l1_dir  = bus.dir;
    assign l1_mode = mode_t'(bus.mode);
    assign l1_en   = bus.shamt[0];

    assign out_rdy = !out_valid_q || bus.out_ready;

`ifdef BSHIFT8_STAGE_PIPE_EN
    slot_t s1_q, s1_d, s2_q, s2_d;
    logic  rdy1, rdy2;
    logic  unused_shamt_bits;

    // Each slot keeps the raw shamt; later levels look only at their own bit.
    assign unused_shamt_bits = ^{s1_q.shamt[0], s2_q.shamt[1:0]};

    assign l2_in   = s1_q.data;
    assign l2_dir  = s1_q.dir;
    assign l2_mode = s1_q.mode;
    assign l2_en   = s1_q.shamt[1];
    assign l4_in   = s2_q.data;
    assign l4_dir  = s2_q.dir;
    assign l4_mode = s2_q.mode;
    assign l4_en   = s2_q.shamt[2];

    assign rdy2         = !s2_q.valid || out_rdy;
    assign rdy1         = !s1_q.valid || rdy2;
    assign bus.in_ready = rdy1;

    always_comb begin
        s1_d        = s1_q;
        s2_d        = s2_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (rdy1) begin
            s1_d.valid = bus.in_valid;
            if (bus.in_valid) begin
                s1_d.data  = l1_out;
                s1_d.dir   = bus.dir;
                s1_d.mode  = mode_t'(bus.mode);
                s1_d.shamt = bus.shamt;
            end
        end
        if (rdy2) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d      = s1_q;
                s2_d.data = l2_out;
            end
        end
        if (out_rdy) begin
            out_valid_d = s2_q.valid;
            if (s2_q.valid) out_data_d = l4_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= SLOT_IDLE;
            s2_q        <= SLOT_IDLE;
            out_data_q  <= RESET_DOUT;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
`else
    assign l2_in   = l1_out;
    assign l2_dir  = bus.dir;
    assign l2_mode = mode_t'(bus.mode);
    assign l2_en   = bus.shamt[1];
    assign l4_in   = l2_out;
    assign l4_dir  = bus.dir;
    assign l4_mode = mode_t'(bus.mode);
    assign l4_en   = bus.shamt[2];

    assign bus.in_ready = out_rdy;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_rdy) begin
            out_valid_d = bus.in_valid;
            if (bus.in_valid) out_data_d = l4_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= RESET_DOUT;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    bshift8_level #(.DIST(1)) u_lvl1 (
        .data_i (l1_in),
        .dir_i  (l1_dir),
        .mode_i (l1_mode),
        .en_i   (l1_en),
        .data_o (l1_out)
    );

    bshift8_level #(.DIST(2)) u_lvl2 (
        .data_i (l2_in),
        .dir_i  (l2_dir),
        .mode_i (l2_mode),
        .en_i   (l2_en),
        .data_o (l2_out)
    );

    bshift8_level #(.DIST(4)) u_lvl4 (
        .data_i (l4_in),
        .dir_i  (l4_dir),
        .mode_i (l4_mode),
        .en_i   (l4_en),
        .data_o (l4_out)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = out_data_q;

endmodule

// File: tb/tb_bshift8_stage.sv
// tb/tb_bshift8_stage.sv - directed vector bench for bshift8_stage in either BSHIFT8_STAGE_PIPE_EN build
module tb_bshift8_stage;

`ifdef BSHIFT8_STAGE_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [7:0] RST_VAL = 8'h5A;
    localparam int NVEC = 17;

    typedef struct {
        logic [7:0] din;
        logic [2:0] shamt;
        logic       dir;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t vt [NVEC];
    int   n_cmp = 0;
    int   n_err = 0;

    bshift8_stage_if bus ();

    bshift8_stage #(.RESET_DOUT(RST_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        bus.din   = vt[i].din;
        bus.shamt = vt[i].shamt;
        bus.dir   = vt[i].dir;
        bus.mode  = vt[i].mode;
    endtask

    task automatic run_vec(input int i);
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(i);
        #1;
        chk($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("vec%0d_latency", i), lat, LAT);
        chk($sformatf("vec%0d_dout", i), {24'd0, bus.dout}, {24'd0, vt[i].exp});
        step();
    endtask

    initial begin
        int sent, received, dropped, stalled_prev, seen;
        logic [7:0] prev_dout;

        vt[0]  = '{8'hB4, 3'd3, 1'b0, 2'b00, 8'hA0};
        vt[1]  = '{8'hB4, 3'd2, 1'b1, 2'b01, 8'hED};
        vt[2]  = '{8'hB4, 3'd2, 1'b1, 2'b00, 8'h2D};
        vt[3]  = '{8'hB4, 3'd3, 1'b1, 2'b10, 8'h96};
        vt[4]  = '{8'hB4, 3'd1, 1'b0, 2'b10, 8'h69};
        vt[5]  = '{8'hB4, 3'd0, 1'b0, 2'b10, 8'hB4};
        vt[6]  = '{8'hB4, 3'd5, 1'b0, 2'b11, 8'hB4};
        vt[7]  = '{8'hB4, 3'd2, 1'b0, 2'b01, 8'hD0};
        vt[8]  = '{8'hB4, 3'd7, 1'b1, 2'b00, 8'h01};
        vt[9]  = '{8'hB4, 3'd7, 1'b1, 2'b01, 8'hFF};
        vt[10] = '{8'h34, 3'd3, 1'b1, 2'b01, 8'h06};
        vt[11] = '{8'hB4, 3'd4, 1'b0, 2'b10, 8'h4B};
        vt[12] = '{8'hB4, 3'd7, 1'b1, 2'b10, 8'h69};
        vt[13] = '{8'h01, 3'd7, 1'b0, 2'b00, 8'h80};
        vt[14] = '{8'h80, 3'd1, 1'b1, 2'b01, 8'hC0};
        vt[15] = '{8'h81, 3'd5, 1'b0, 2'b10, 8'h30};
        vt[16] = '{8'h5A, 3'd0, 1'b1, 2'b01, 8'h5A};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_dout", {24'd0, bus.dout}, {24'd0, RST_VAL});
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // Streaming with a 4-cycle downstream stall in the middle.
        sent = 0; received = 0; dropped = 0; stalled_prev = 0; prev_dout = '0;
        for (int cyc = 0; cyc < 60 && received < 8; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            bus.in_valid  = (sent < 8);
            drive(sent < 8 ? sent : 0);
            #1;
            if (!bus.in_ready) dropped = 1;
            if (stalled_prev != 0) begin
                chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_dout", {24'd0, bus.dout}, {24'd0, prev_dout});
            end
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("stream%0d_dout", received), {24'd0, bus.dout}, {24'd0, vt[received].exp});
                received++;
            end
            stalled_prev = (bus.out_valid && !bus.out_ready) ? 1 : 0;
            prev_dout    = bus.dout;
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_count", received, 8);
        chk("stream_in_ready_dropped", dropped, 1);
        step();
        chk("stream_drained", {31'd0, bus.out_valid}, 32'd0);

        // Mid-stream reset with operands in flight and an operand offered during reset.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(0);
        step();
        drive(1);
        step();
        rst = 1'b1;
        drive(2);
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_dout", {24'd0, bus.dout}, {24'd0, RST_VAL});
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.out_valid) seen = 1;
        end
        chk("midrst_no_result", seen, 0);
        run_vec(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
